// File: rtl/input_vc_scheduler.sv
// Moves flits from the input FIFO into NUM_VC virtual-channel buffers: head flits get a
// free VC round-robin, the packet keeps that VC until its tail, and the VC stays busy until released.
module input_vc_scheduler #(
  parameter int NUM_VC = 4,
  parameter int VC_W   = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_empty,
  input  logic              in_head,
  input  logic              in_tail,
  input  logic [NUM_VC-1:0] vc_full,
  input  logic [NUM_VC-1:0] vc_release,
  output logic              input_read,
  output logic [NUM_VC-1:0] vc_write,
  output logic [NUM_VC-1:0] vc_busy,
  output logic [VC_W-1:0]   cur_vc,
  output logic              proto_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [VC_W-1:0]   rr_ptr;
  logic [VC_W-1:0]   grant_idx;
  logic              grant_ok;
  logic [NUM_VC-1:0] free_vc;
  logic [NUM_VC-1:0] release_mask;
  logic [NUM_VC-1:0] busy_next;

  function automatic logic [VC_W-1:0] wrap_inc(input logic [VC_W-1:0] v);
    return (int'(v) == NUM_VC - 1) ? '0 : v + VC_W'(1);
  endfunction

  assign free_vc = ~vc_busy & ~vc_full;

  // First free VC at or after rr_ptr, wrapping past NUM_VC-1 (NUM_VC need not be a power of 2)
  always_comb begin
    int              idx_i;
    logic [VC_W-1:0] idx;
    grant_ok  = 1'b0;
    grant_idx = '0;
    idx_i     = 0;
    idx       = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NUM_VC) idx_i = idx_i - NUM_VC;
      idx = VC_W'(idx_i);
      if (!grant_ok && free_vc[idx]) begin
        grant_ok  = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    input_read = 1'b0;
    vc_write   = '0;
    if (!reset && !input_empty) begin
      case (state)
        IDLE: begin
          if (in_head) begin
            if (grant_ok) begin
              input_read          = 1'b1;
              vc_write[grant_idx] = 1'b1;
            end
          end else begin
            input_read = 1'b1;
          end
        end
        ACTIVE: begin
          if (!in_head && !vc_full[cur_vc]) begin
            input_read       = 1'b1;
            vc_write[cur_vc] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The packet in flight cannot lose its own VC to a release pulse
  always_comb begin
    release_mask = vc_release;
    if (state == ACTIVE) release_mask[cur_vc] = 1'b0;
    busy_next = (vc_busy & ~release_mask) | ((state == IDLE) ? vc_write : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vc_busy   <= '0;
      cur_vc    <= '0;
      rr_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      vc_busy <= busy_next;
      if (!input_empty) begin
        case (state)
          IDLE: begin
            if (in_head) begin
              if (grant_ok) begin
                cur_vc <= grant_idx;
                rr_ptr <= wrap_inc(grant_idx);
                if (!in_tail) state <= ACTIVE;
              end
            end else begin
              proto_err <= 1'b1;
            end
          end
          ACTIVE: begin
            if (in_head) begin
              proto_err <= 1'b1;
              state     <= IDLE;
            end else if (!vc_full[cur_vc] && in_tail) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_vc_scheduler.sv
// Bench for input_vc_scheduler: vector table, hand-written corner sequences, then random
// traffic against a packet-level reference model.
module tb_input_vc_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         input_empty, in_head, in_tail;
  logic [N-1:0] vc_full, vc_release;
  logic         input_read;
  logic [N-1:0] vc_write, vc_busy;
  logic [1:0]   cur_vc;
  logic         proto_err;

  int errors = 0;
  int checks = 0;

  input_vc_scheduler #(.NUM_VC(N)) dut (
    .clk(clk), .reset(reset), .input_empty(input_empty), .in_head(in_head),
    .in_tail(in_tail), .vc_full(vc_full), .vc_release(vc_release),
    .input_read(input_read), .vc_write(vc_write), .vc_busy(vc_busy),
    .cur_vc(cur_vc), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e, h, t;
    logic [3:0] f, r;
    logic       xr;
    logic [3:0] xw, xb;
    logic [1:0] xc;
    logic       xp;
  } vec_t;

  vec_t tbl[22];

  // reference model state
  logic [N-1:0] m_busy;
  bit           m_act;
  int           m_cur, m_rr;
  bit           m_perr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check combinational outputs, clock, check registers.
  task automatic run(input string nm, input logic e, h, t, input logic [3:0] f, r,
                     input logic xr, input logic [3:0] xw, xb, input logic [1:0] xc,
                     input logic xp);
    input_empty = e; in_head = h; in_tail = t; vc_full = f; vc_release = r;
    #3;
    chk({nm, " input_read"}, 32'(input_read), 32'(xr));
    chk({nm, " vc_write"}, 32'(vc_write), 32'(xw));
    @(posedge clk); #1;
    vc_release = '0;
    chk({nm, " vc_busy"}, 32'(vc_busy), 32'(xb));
    chk({nm, " cur_vc"}, 32'(cur_vc), 32'(xc));
    chk({nm, " proto_err"}, 32'(proto_err), 32'(xp));
  endtask

  function automatic vec_t mk(input logic e, h, t, input logic [3:0] f, r, input logic xr,
                              input logic [3:0] xw, xb, input logic [1:0] xc, input logic xp);
    vec_t v;
    v.e = e; v.h = h; v.t = t; v.f = f; v.r = r;
    v.xr = xr; v.xw = xw; v.xb = xb; v.xc = xc; v.xp = xp;
    return v;
  endfunction

  // One cycle of the packet-level rules; returns expected strobes and updates model state.
  task automatic model_step(input logic e, h, t, input logic [N-1:0] f, r,
                            output logic xr, output logic [N-1:0] xw);
    bit act0 = m_act;
    int cur0 = m_cur;
    int g = -1;
    xr = 1'b0; xw = '0;
    if (!e) begin
      if (!act0) begin
        if (h) begin
          for (int k = 0; k < N; k++) begin
            int i = (m_rr + k) % N;
            if (g < 0 && !m_busy[i] && !f[i]) g = i;
          end
          if (g >= 0) begin
            xr = 1'b1; xw[g] = 1'b1;
            m_cur = g; m_rr = (g + 1) % N;
            m_act = !t;
          end
        end else begin
          xr = 1'b1; m_perr = 1'b1;
        end
      end else if (h) begin
        m_perr = 1'b1; m_act = 1'b0;
      end else if (!f[cur0]) begin
        xr = 1'b1; xw[cur0] = 1'b1;
        if (t) m_act = 1'b0;
      end
    end
    for (int i = 0; i < N; i++)
      if (r[i] && !(act0 && i == cur0)) m_busy[i] = 1'b0;
    if (g >= 0) m_busy[g] = 1'b1;
  endtask

  initial begin
    // e h t full rel | read write busy cur perr
    tbl[0]  = mk(0,1,0,4'b0000,4'b0000, 1,4'b0001,4'b0001,2'd0,0);
    tbl[1]  = mk(0,0,0,4'b0000,4'b0000, 1,4'b0001,4'b0001,2'd0,0);
    tbl[2]  = mk(0,0,1,4'b0000,4'b0000, 1,4'b0001,4'b0001,2'd0,0);
    tbl[3]  = mk(1,0,0,4'b0000,4'b0001, 0,4'b0000,4'b0000,2'd0,0);
    tbl[4]  = mk(0,1,1,4'b0000,4'b0000, 1,4'b0010,4'b0010,2'd1,0);
    tbl[5]  = mk(0,1,1,4'b0000,4'b0000, 1,4'b0100,4'b0110,2'd2,0);
    tbl[6]  = mk(0,1,1,4'b0000,4'b0000, 1,4'b1000,4'b1110,2'd3,0);
    tbl[7]  = mk(0,1,1,4'b0000,4'b0000, 1,4'b0001,4'b1111,2'd0,0);
    tbl[8]  = mk(0,1,1,4'b0000,4'b0000, 0,4'b0000,4'b1111,2'd0,0);
    tbl[9]  = mk(0,1,1,4'b0000,4'b0100, 0,4'b0000,4'b1011,2'd0,0);
    tbl[10] = mk(0,1,1,4'b0000,4'b0000, 1,4'b0100,4'b1111,2'd2,0);
    tbl[11] = mk(1,0,0,4'b0000,4'b0011, 0,4'b0000,4'b1100,2'd2,0);
    tbl[12] = mk(0,1,0,4'b0000,4'b0000, 1,4'b0001,4'b1101,2'd0,0);
    tbl[13] = mk(0,0,0,4'b0000,4'b0001, 1,4'b0001,4'b1101,2'd0,0);
    tbl[14] = mk(0,0,1,4'b0000,4'b0000, 1,4'b0001,4'b1101,2'd0,0);
    tbl[15] = mk(0,1,1,4'b0000,4'b1000, 1,4'b0010,4'b0111,2'd1,0);
    tbl[16] = mk(0,1,1,4'b1000,4'b0000, 0,4'b0000,4'b0111,2'd1,0);
    tbl[17] = mk(0,0,0,4'b0000,4'b0000, 1,4'b0000,4'b0111,2'd1,1);
    tbl[18] = mk(1,0,0,4'b0000,4'b0111, 0,4'b0000,4'b0000,2'd1,1);
    tbl[19] = mk(0,1,0,4'b0000,4'b0000, 1,4'b0100,4'b0100,2'd2,1);
    tbl[20] = mk(0,1,0,4'b0000,4'b0000, 0,4'b0000,4'b0100,2'd2,1);
    tbl[21] = mk(0,1,1,4'b0000,4'b0000, 1,4'b1000,4'b1100,2'd3,1);

    reset = 1'b1; input_empty = 1'b0; in_head = 1'b1; in_tail = 1'b0;
    vc_full = '0; vc_release = '0;
    #1;
    chk("reset input_read", 32'(input_read), 0);
    chk("reset vc_write", 32'(vc_write), 0);
    chk("reset vc_busy", 32'(vc_busy), 0);
    chk("reset cur_vc", 32'(cur_vc), 0);
    chk("reset proto_err", 32'(proto_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 22; i++)
      run($sformatf("vec%0d", i), tbl[i].e, tbl[i].h, tbl[i].t, tbl[i].f, tbl[i].r,
          tbl[i].xr, tbl[i].xw, tbl[i].xb, tbl[i].xc, tbl[i].xp);

    // full stall mid-packet: busy=1100, rr=0
    run("stall head", 0,1,0,4'b0000,4'b0000, 1,4'b0001,4'b1101,2'd0,1);
    for (int i = 0; i < 3; i++)
      run("stall full", 0,0,0,4'b0001,4'b0000, 0,4'b0000,4'b1101,2'd0,1);
    run("stall body", 0,0,0,4'b0000,4'b0000, 1,4'b0001,4'b1101,2'd0,1);
    run("stall tail", 0,0,1,4'b0000,4'b0000, 1,4'b0001,4'b1101,2'd0,1);
    run("stall rr", 0,1,1,4'b0000,4'b0000, 1,4'b0010,4'b1111,2'd1,1);

    // reset in the middle of a packet
    run("mid drain", 1,0,0,4'b0000,4'b1111, 0,4'b0000,4'b0000,2'd1,1);
    run("mid head", 0,1,0,4'b0000,4'b0000, 1,4'b0100,4'b0100,2'd2,1);
    run("mid body", 0,0,0,4'b0000,4'b0000, 1,4'b0100,4'b0100,2'd2,1);
    input_empty = 1'b0; in_head = 1'b0; in_tail = 1'b0; reset = 1'b1;
    #3;
    chk("midrst input_read", 32'(input_read), 0);
    chk("midrst vc_write", 32'(vc_write), 0);
    chk("midrst vc_busy", 32'(vc_busy), 0);
    chk("midrst cur_vc", 32'(cur_vc), 0);
    chk("midrst proto_err", 32'(proto_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run("post rst head", 0,1,1,4'b0000,4'b0000, 1,4'b0001,4'b0001,2'd0,0);

    // randomized traffic against the model
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_busy = '0; m_act = 0; m_cur = 0; m_rr = 0; m_perr = 0;
    for (int c = 0; c < 3000; c++) begin
      logic         e, h, t, xr;
      logic [N-1:0] f, r, xw;
      e = ($urandom % 5) == 0;
      h = ($urandom % 3) == 0;
      t = ($urandom % 3) == 0;
      f = N'($urandom & $urandom & $urandom);
      r = N'($urandom & $urandom);
      if (c % 500 < 20) h = 1'b1;
      model_step(e, h, t, f, r, xr, xw);
      run("rand", e, h, t, f, r, xr, xw, m_busy, 2'(m_cur), m_perr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
